// File: rtl/fft_mem_pkg.sv
// Shared types for the FFT memory path: arbiter states and requester ids.
package fft_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    localparam logic RQ0 = 1'b0;
    localparam logic RQ1 = 1'b1;

endpackage

// File: rtl/fft_sdram_arbiter_route_fifo.sv
// 1-bit synchronous FIFO holding the requester id of each read in flight.
// Head is visible combinationally; push is ignored when full, pop when empty.
module route_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == DEPTH[AW:0]);
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fft_sdram_arbiter.sv
// Round-robin share of one SDRAM Avalon-MM port between two masters; zero added latency.
// Grant locks while m_waitrequest stalls; reads are held off while the route FIFO is full.
module fft_sdram_arbiter
    import fft_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            rq0_address,
    input  logic                         rq0_read,
    input  logic                         rq0_write,
    input  logic [DATA_W-1:0]            rq0_writedata,
    output logic                         rq0_waitrequest,
    output logic [DATA_W-1:0]            rq0_readdata,
    output logic                         rq0_readdatavalid,
    input  logic [ADDR_W-1:0]            rq1_address,
    input  logic                         rq1_read,
    input  logic                         rq1_write,
    input  logic [DATA_W-1:0]            rq1_writedata,
    output logic                         rq1_waitrequest,
    output logic [DATA_W-1:0]            rq1_readdata,
    output logic                         rq1_readdatavalid,
    output logic [ADDR_W-1:0]            m_address,
    output logic                         m_read,
    output logic                         m_write,
    output logic [DATA_W-1:0]            m_writedata,
    input  logic                         m_waitrequest,
    input  logic [DATA_W-1:0]            m_readdata,
    input  logic                         m_readdatavalid,
    output logic [$clog2(MAX_OUTST):0]   outstanding,
    output logic                         err_unexpected_rdv
);

    arb_state_t state, state_nxt;
    logic       last_served;
    logic       req0, req1;
    logic       gnt_vld, gnt_id;
    logic       sel_read, sel_write;
    logic       accept;
    logic       fifo_full, fifo_empty, fifo_head;

    // A read is only a candidate while a route slot is free; read wins over write.
    assign req0 = rq0_read ? ~fifo_full : rq0_write;
    assign req1 = rq1_read ? ~fifo_full : rq1_write;

    always_comb begin
        state_nxt = state;
        gnt_vld   = 1'b0;
        gnt_id    = RQ0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~last_served;
                end else if (req0) begin
                    gnt_vld = 1'b1;
                    gnt_id  = RQ0;
                end else if (req1) begin
                    gnt_vld = 1'b1;
                    gnt_id  = RQ1;
                end
            end
            OWN0: begin
                gnt_vld = 1'b1;
                gnt_id  = RQ0;
            end
            OWN1: begin
                gnt_vld = 1'b1;
                gnt_id  = RQ1;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) gnt_vld = 1'b0;

        sel_read    = (gnt_id == RQ1) ? rq1_read      : rq0_read;
        sel_write   = (gnt_id == RQ1) ? rq1_write     : rq0_write;
        m_address   = (gnt_id == RQ1) ? rq1_address   : rq0_address;
        m_writedata = (gnt_id == RQ1) ? rq1_writedata : rq0_writedata;
        m_read      = gnt_vld & sel_read;
        m_write     = gnt_vld & ~sel_read & sel_write;
        accept      = (m_read | m_write) & ~m_waitrequest;

        rq0_waitrequest = (gnt_vld && gnt_id == RQ0) ? m_waitrequest : 1'b1;
        rq1_waitrequest = (gnt_vld && gnt_id == RQ1) ? m_waitrequest : 1'b1;

        // A dropped command while locked would otherwise wedge the grant.
        if (gnt_vld) begin
            if (accept || !(m_read || m_write)) state_nxt = IDLE;
            else                                state_nxt = (gnt_id == RQ1) ? OWN1 : OWN0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_served        <= RQ1;
            err_unexpected_rdv <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) last_served <= gnt_id;
            if (m_readdatavalid && fifo_empty) err_unexpected_rdv <= 1'b1;
        end
    end

    route_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept & m_read),
        .push_id (gnt_id),
        .pop     (m_readdatavalid & ~fifo_empty),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding)
    );

    assign rq0_readdata      = m_readdata;
    assign rq1_readdata      = m_readdata;
    assign rq0_readdatavalid = m_readdatavalid & ~fifo_empty & (fifo_head == RQ0);
    assign rq1_readdatavalid = m_readdatavalid & ~fifo_empty & (fifo_head == RQ1);

endmodule

// File: doc/fft_sdram_arbiter.md
Name: fft_sdram_arbiter

Overview:
- Shares one SDRAM-facing Avalon-MM master port between the FFT wrapper's two Avalon-MM masters (requester 0 = x0/y0 stream, requester 1 = x2/y2 stream).
- Round-robin arbitration per transfer, with the grant locked while the downstream stalls.
- Pipelined reads; a route FIFO returns each read datum to the requester that issued it.
- Sits between fft_wrapper and the SDRAM controller.

Parameters:
DATA_W, 32, data width of all ports
ADDR_W, 32, address width of all ports
MAX_OUTST, 8, maximum outstanding reads; route FIFO depth; power of 2, at least 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rq0_address  in  ADDR_W  requester 0 address
rq0_read  in  1  requester 0 read request
rq0_write  in  1  requester 0 write request
rq0_writedata  in  DATA_W  requester 0 write data
rq0_waitrequest  out  1  stall to requester 0
rq0_readdata  out  DATA_W  read data to requester 0
rq0_readdatavalid  out  1  read data valid to requester 0
rq1_*  (same seven signals, same directions and widths)  requester 1
m_address  out  ADDR_W  SDRAM address
m_read  out  1  SDRAM read
m_write  out  1  SDRAM write
m_writedata  out  DATA_W  SDRAM write data
m_waitrequest  in  1  SDRAM stall
m_readdata  in  DATA_W  SDRAM read data
m_readdatavalid  in  1  SDRAM read data valid
outstanding  out  $clog2(MAX_OUTST)+1  reads in flight
err_unexpected_rdv  out  1  sticky; set when readdatavalid arrives with the route FIFO empty

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - m_read = 0, m_write = 0.
  - rq0_waitrequest = 1, rq1_waitrequest = 1.
  - rqN_readdatavalid = 0.
  - route FIFO empty; outstanding = 0; err_unexpected_rdv = 0.
  - last_served = 1, so requester 0 wins the first contention.
- Definitions:
  - reqN = rqN_read | rqN_write. Simultaneous read and write from one requester is illegal; read takes precedence.
  - accept = (m_read | m_write) & ~m_waitrequest.
- State machine, states IDLE, OWN0, OWN1:
  - IDLE: grant is combinational.
    - Only one requester requesting: that requester.
    - Both requesting: the one that is not last_served.
  - A granted transfer is driven on m_* in the same cycle.
    - If accept, last_served <= winner and the state stays IDLE.
    - If stalled, the state moves to OWNn. The grant is held until accept, then returns to IDLE.
  - Avalon stability rule: requesters hold their command while waitrequest is high, so a locked grant never switches mid-transfer.
- Outputs per state:
  - m_* mirror the granted requester's command. With no grant, m_read and m_write are 0.
  - Granted rqN_waitrequest = m_waitrequest. Non-granted rqN_waitrequest = 1.
- Read throttle:
  - When the route FIFO is full, a read is not granted: m_read = 0 and the requester's waitrequest = 1. Writes may still be granted.
  - Full is evaluated before any same-cycle pop. Freeing a slot takes effect the next cycle.
- Route FIFO:
  - On accept of a read, push the 1-bit requester id.
  - On m_readdatavalid, pop.
  - Push and pop in the same cycle are both legal when the FIFO is neither empty nor full.
  - outstanding tracks pushes minus pops.
- Read return:
  - rqN_readdata = m_readdata for both requesters, combinational, zero added latency.
  - rqN_readdatavalid = m_readdatavalid & (FIFO head == N).
- Error case: m_readdatavalid with the FIFO empty sets err_unexpected_rdv. Nothing is popped and no requester readdatavalid is asserted. Only rst clears the flag.
- Reset mid-operation: in-flight reads are abandoned and later readdatavalid pulses raise the error flag. The system requires rst to be applied to the SDRAM side as well.
- Ordering: the SDRAM returns reads in order, so FIFO order equals return order.

Decomposition:
- Shared package fft_mem_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}
  - requester id constants RQ0 = 1'b0, RQ1 = 1'b1
- One sub-module: route_fifo. Parameterised depth, 1-bit synchronous FIFO with push, pop, head, full, empty and count outputs.

Test Plan:
- Only rq0 reads addresses 0x0–0x3 back-to-back, m_waitrequest = 0, SDRAM returns data 0xA0–0xA3 two cycles later -> rq0 receives 4 readdatavalid pulses with 0xA0–0xA3; rq1_readdatavalid stays 0; outstanding peaks at 2 and ends at 0.
- rq0 and rq1 both read continuously for 8 transfers -> grants alternate 0,1,0,1…, rq0 first; returned data 0x100 + k is routed to the correct requester each time.
- rq1 write 0xDEAD to 0x40 stalled by m_waitrequest = 1 for 3 cycles while rq0 raises a read -> m_address/m_writedata hold 0x40/0xDEAD for all stall cycles; rq0 is granted on the cycle after accept.
- MAX_OUTST = 8, 8 reads accepted with no return -> the 9th read sees rq0_waitrequest = 1 and m_read = 0; a concurrent rq1 write is still accepted; after one readdatavalid, the read is granted next cycle.
- m_readdatavalid pulsed with nothing outstanding -> err_unexpected_rdv = 1 and stays set; no requester readdatavalid.
- Assert rst with 3 reads outstanding -> next cycle outstanding = 0, both waitrequests = 1, m_read = 0; the flag clears only through rst.
